// File: rtl/dac_spi_pkg.sv
// Shared constants for the DAC-format SPI receiver: frame layout, command/address codes
// and controller state encoding.
package dac_spi_pkg;

  localparam int unsigned FRAME_BITS = 24;

  localparam int unsigned CMD_MSB   = 23;
  localparam int unsigned CMD_LSB   = 20;
  localparam int unsigned ADDR_MSB  = 19;
  localparam int unsigned ADDR_LSB  = 16;
  localparam int unsigned VALUE_MSB = 15;
  localparam int unsigned VALUE_LSB = 0;

  localparam logic [3:0] CMD_WRITE_N          = 4'b0000;
  localparam logic [3:0] CMD_UPDATE_N         = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'b0010;
  localparam logic [3:0] CMD_WRITE_UPDATE_N   = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN_N     = 4'b0100;
  localparam logic [3:0] CMD_NOP              = 4'b1111;

  localparam logic [3:0] ADDR_A   = 4'b0000;
  localparam logic [3:0] ADDR_B   = 4'b0001;
  localparam logic [3:0] ADDR_C   = 4'b0010;
  localparam logic [3:0] ADDR_D   = 4'b0011;
  localparam logic [3:0] ADDR_ALL = 4'b1111;

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for a bundle of async inputs, with a trailing flop for
// single-cycle rise/fall detection on the synchronized levels.
module spi_input_sync #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] level,
  output logic [Width-1:0] rise,
  output logic [Width-1:0] fall
);

  logic [Width-1:0] stage_q [Depth];
  logic [Width-1:0] prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[Depth-1];
    end
  end

  assign level = stage_q[Depth-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/dac_spi_receiver.sv
// SPI target for 24-bit DAC frames: oversamples SCLK/CS/SDI, checks frame length,
// publishes decoded fields with valid/error pulses and echoes the last good frame on SDO.
module dac_spi_receiver #(
  parameter int unsigned FRAME_BITS  = dac_spi_pkg::FRAME_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        rx_valid,
  output logic        rx_error,
  output logic [3:0]  rx_cmd,
  output logic [3:0]  rx_addr,
  output logic [15:0] rx_value,
  output logic        rx_busy,
  output logic [15:0] frame_count
);
  import dac_spi_pkg::state_e;
  import dac_spi_pkg::StWaitIdle;
  import dac_spi_pkg::StIdle;
  import dac_spi_pkg::StShift;
  import dac_spi_pkg::CMD_MSB;
  import dac_spi_pkg::CMD_LSB;
  import dac_spi_pkg::ADDR_MSB;
  import dac_spi_pkg::ADDR_LSB;
  import dac_spi_pkg::VALUE_MSB;
  import dac_spi_pkg::VALUE_LSB;

  logic [2:0] sync_level, sync_rise, sync_fall;

  spi_input_sync #(
    .Width (3),
    .Depth (SYNC_STAGES)
  ) u_sync (
    .clk   (clk25),
    .reset (reset),
    .din   ({spi_sdi, spi_cs_n, spi_sclk}),
    .level (sync_level),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  logic sclk_rise, sclk_fall, cs_level, cs_rise, cs_fall, sdi_level;
  assign sclk_rise = sync_rise[0];
  assign sclk_fall = sync_fall[0];
  assign cs_level  = sync_level[1];
  assign cs_rise   = sync_rise[1];
  assign cs_fall   = sync_fall[1];
  assign sdi_level = sync_level[2];

  state_e state_q, state_d;

  logic [23:0] shift_q, sdo_sr_q, echo_q;
  logic [5:0]  bit_cnt_q;
  logic        eval_q, valid_q, error_q;
  logic [3:0]  cmd_q, addr_q;
  logic [15:0] value_q, count_q;
  logic        frame_good;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitIdle: if (cs_level) state_d = StIdle;
      StIdle:     if (cs_fall)  state_d = StShift;
      StShift:    if (cs_rise)  state_d = StIdle;
      default:                  state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) state_q <= StWaitIdle;
    else        state_q <= state_d;
  end

  assign frame_good = (bit_cnt_q == 6'(FRAME_BITS));

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      sdo_sr_q  <= '0;
      echo_q    <= '0;
      bit_cnt_q <= '0;
      eval_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      value_q   <= '0;
      count_q   <= '0;
    end else begin
      if (state_q == StIdle && cs_fall) begin
        bit_cnt_q <= '0;
        sdo_sr_q  <= echo_q;
      end else if (state_q == StShift && !cs_rise) begin
        // A CS rise wins over a coincident SCLK edge, so shifting is gated on !cs_rise.
        if (sclk_rise) begin
          shift_q <= {shift_q[22:0], sdi_level};
          if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + 6'd1;
        end
        if (sclk_fall) sdo_sr_q <= {sdo_sr_q[22:0], 1'b0};
      end

      eval_q  <= (state_q == StShift) && cs_rise;
      valid_q <= eval_q && frame_good;
      error_q <= eval_q && !frame_good;

      if (eval_q && frame_good) begin
        cmd_q   <= shift_q[CMD_MSB:CMD_LSB];
        addr_q  <= shift_q[ADDR_MSB:ADDR_LSB];
        value_q <= shift_q[VALUE_MSB:VALUE_LSB];
        echo_q  <= shift_q;
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign spi_sdo     = (state_q == StShift) ? sdo_sr_q[23] : 1'b0;
  assign rx_busy     = (state_q == StShift);
  assign rx_valid    = valid_q;
  assign rx_error    = error_q;
  assign rx_cmd      = cmd_q;
  assign rx_addr     = addr_q;
  assign rx_value    = value_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed and randomized frames against a frame-level model of the DAC SPI receiver.
module tb_dac_spi_receiver;

  localparam int SyncStages = 2;

  logic        clk25 = 1'b0;
  logic        reset;
  logic        spi_sclk, spi_cs_n, spi_sdi;
  logic        spi_sdo, rx_valid, rx_error, rx_busy;
  logic [3:0]  rx_cmd, rx_addr;
  logic [15:0] rx_value, frame_count;

  dac_spi_receiver #(
    .FRAME_BITS  (24),
    .SYNC_STAGES (SyncStages)
  ) dut (
    .clk25       (clk25),
    .reset       (reset),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_sdi     (spi_sdi),
    .spi_sdo     (spi_sdo),
    .rx_valid    (rx_valid),
    .rx_error    (rx_error),
    .rx_cmd      (rx_cmd),
    .rx_addr     (rx_addr),
    .rx_value    (rx_value),
    .rx_busy     (rx_busy),
    .frame_count (frame_count)
  );

  always #20 clk25 = ~clk25;

  int vectors = 0;
  int miscompares = 0;
  int valid_seen = 0;
  int error_seen = 0;
  int both_seen = 0;

  // Reference model state: what the receiver should be holding after each frame.
  logic [3:0]  cmd_m, addr_m;
  logic [15:0] value_m, count_m;
  logic [23:0] echo_m;

  always @(negedge clk25) begin
    if (rx_valid) valid_seen <= valid_seen + 1;
    if (rx_error) error_seen <= error_seen + 1;
    if (rx_valid && rx_error) both_seen <= both_seen + 1;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic shift_bits(input logic [31:0] data, input int nbits, input int half,
                            input bit chk_sdo);
    logic exp_bit;
    for (int i = 0; i < nbits; i++) begin
      spi_sdi = data[nbits-1-i];
      wait_cycles(half);
      if (chk_sdo) begin
        exp_bit = (i < 24) ? echo_m[23-i] : 1'b0;
        check($sformatf("sdo_bit%0d", i), 32'(spi_sdo), 32'(exp_bit));
      end
      spi_sclk = 1'b1;
      wait_cycles(half);
      spi_sclk = 1'b0;
    end
    wait_cycles(4);
  endtask

  task automatic start_frame();
    spi_cs_n = 1'b0;
    wait_cycles(4);
    check("busy_in_frame", 32'(rx_busy), 32'd1);
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_cmd"},   32'(rx_cmd),      32'(cmd_m));
    check({tag, "_addr"},  32'(rx_addr),     32'(addr_m));
    check({tag, "_value"}, 32'(rx_value),    32'(value_m));
    check({tag, "_count"}, 32'(frame_count), 32'(count_m));
  endtask

  task automatic end_frame(input logic [23:0] frame, input bit good);
    int v0, e0, n;
    v0 = valid_seen;
    e0 = error_seen;
    spi_cs_n = 1'b1;
    n = 0;
    while (n < 12) begin
      @(posedge clk25);
      #1;
      n++;
      if (rx_valid || rx_error) break;
    end
    if (!(rx_valid || rx_error)) n = 13;
    check("pulse_latency", 32'(n), 32'(SyncStages + 2));
    check("pulse_valid", 32'(rx_valid), 32'(good));
    check("pulse_error", 32'(rx_error), 32'(!good));
    if (good) begin
      cmd_m   = 4'((frame >> 20) & 24'hF);
      addr_m  = 4'((frame >> 16) & 24'hF);
      value_m = 16'(frame & 24'hFFFF);
      echo_m  = frame;
      count_m = count_m + 16'd1;
    end
    wait_cycles(3);
    check("valid_pulses", 32'(valid_seen - v0), 32'(good));
    check("error_pulses", 32'(error_seen - e0), 32'(!good));
    check("busy_after", 32'(rx_busy), 32'd0);
    check_fields("frame");
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input int half,
                            input bit chk_sdo);
    start_frame();
    shift_bits(data, nbits, half, chk_sdo);
    end_frame(24'(data), nbits == 24);
  endtask

  task automatic model_reset();
    cmd_m = '0;
    addr_m = '0;
    value_m = '0;
    count_m = '0;
    echo_m = '0;
  endtask

  initial begin
    int v0, e0, nbits;
    logic [31:0] data;
    reset = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_sdi = 1'b0;
    model_reset();
    wait_cycles(5);
    check("reset_pulses", {30'd0, rx_valid, rx_error}, 32'd0);
    check("reset_sdo_busy", {30'd0, spi_sdo, rx_busy}, 32'd0);
    check_fields("reset");
    reset = 1'b1;
    wait_cycles(6);

    // Full-rate SCLK frame, then an echo pair at a slower SCLK so SDO can be sampled.
    send_frame(32'h31ABCD, 24, 2, 1'b0);
    send_frame(32'h021234, 24, 4, 1'b1);
    send_frame(32'h4F0000, 24, 4, 1'b1);

    // Bad lengths: short, long, and a CS glitch with no clocks.
    send_frame(32'h7FFFFF & 32'h12345A, 23, 4, 1'b1);
    send_frame(32'h1ABCDEF, 25, 4, 1'b1);
    spi_cs_n = 1'b0;
    wait_cycles(6);
    end_frame(24'h0, 1'b0);

    // Reset in the middle of a frame, released while CS is still low.
    start_frame();
    shift_bits(32'h30FFFF >> 14, 10, 4, 1'b0);
    reset = 1'b0;
    model_reset();
    wait_cycles(3);
    check("midreset_pulses", {30'd0, rx_valid, rx_error}, 32'd0);
    check("midreset_sdo_busy", {30'd0, spi_sdo, rx_busy}, 32'd0);
    check_fields("midreset");
    reset = 1'b1;
    wait_cycles(4);
    v0 = valid_seen;
    e0 = error_seen;
    shift_bits(32'h30FFFF & 32'h3FFF, 14, 4, 1'b0);
    spi_cs_n = 1'b1;
    wait_cycles(14);
    check("interrupted_valid", 32'(valid_seen - v0), 32'd0);
    check("interrupted_error", 32'(error_seen - e0), 32'd0);
    send_frame(32'h300055, 24, 4, 1'b1);

    // Counter wrap from a preloaded 0xFFFF.
    force dut.count_q = 16'hFFFF;
    wait_cycles(1);
    release dut.count_q;
    count_m = 16'hFFFF;
    send_frame(32'h2FC0DE, 24, 4, 1'b1);

    // SCLK activity with CS high must be ignored.
    v0 = valid_seen;
    e0 = error_seen;
    for (int i = 0; i < 6; i++) begin
      spi_sdi = i[0];
      spi_sclk = 1'b1;
      wait_cycles(2);
      spi_sclk = 1'b0;
      wait_cycles(2);
    end
    wait_cycles(6);
    check("idle_sclk_pulses", 32'(valid_seen - v0 + error_seen - e0), 32'd0);
    send_frame(32'h138001, 24, 4, 1'b1);

    // Randomized frames, mostly well-formed, some with wrong lengths.
    for (int k = 0; k < 10; k++) begin
      data = $urandom;
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 28)) : 24;
      data = data & ((32'd1 << nbits) - 32'd1);
      send_frame(data, nbits, 4, 1'b1);
    end

    check("never_both", 32'(both_seen), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
